// File: rtl/ber_sweep_sequencer.sv
// BER sweep sequencer: walks the stimulus block through MAIN/SUB modes, times
// clear/settle/dwell, stable-reads the counters and emits one record per step.
module ber_sweep_sequencer #(
  parameter int DWELL_W    = 32,
  parameter int SETTLE     = 16,
  parameter int FIRST_MODE = 9,
  parameter int LAST_MODE  = 31,
  parameter int MAX_TRY    = 4
) (
  input  logic               CLK,
  input  logic               RSTX,
  input  logic               START,
  input  logic               ABORT,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [7:0]         SUB_LAST,
  output logic [7:0]         MAIN_MODE,
  output logic [7:0]         SUB_MODE,
  output logic               CLR,
  input  logic [57:0]        RECV_CNT,
  input  logic [63:0]        ERR_CNT,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [7:0]         RES_MAIN,
  output logic [7:0]         RES_SUB,
  output logic [57:0]        RES_RECV,
  output logic [63:0]        RES_ERR,
  output logic               RES_UNSTABLE,
  output logic               BUSY,
  output logic               DONE
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TRY_W    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

  localparam logic [7:0]          FirstMode  = 8'(FIRST_MODE);
  localparam logic [7:0]          LastMode   = 8'(LAST_MODE);
  localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(SETTLE - 1);
  localparam logic [TRY_W-1:0]    TryLast    = TRY_W'(MAX_TRY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRun,
    StSample,
    StReport
  } state_e;

  state_e              state_q;
  logic [7:0]          mainMode_q;
  logic [7:0]          subMode_q;
  logic                clr_q;
  logic [7:0]          subLast_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [SETTLE_W-1:0] settleCnt_q;
  logic [DWELL_W-1:0]  dwellCnt_q;
  logic [TRY_W-1:0]    tryCnt_q;
  logic                phase_q;
  logic [57:0]         firstRecv_q;
  logic [63:0]         firstErr_q;
  logic                resValid_q;
  logic [7:0]          resMain_q;
  logic [7:0]          resSub_q;
  logic [57:0]         resRecv_q;
  logic [63:0]         resErr_q;
  logic                resUnstable_q;
  logic                busy_q;
  logic                done_q;

  logic [DWELL_W-1:0]  dwellEff_d;
  logic                pairMatch_d;

  always_comb begin
    dwellEff_d  = (DWELL == '0) ? DWELL_W'(1) : DWELL;
    pairMatch_d = (firstRecv_q == RECV_CNT) && (firstErr_q == ERR_CNT);
  end

  // dwellCnt runs 1..dwell so the RUN exit needs no subtraction.
  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_q       <= StIdle;
      mainMode_q    <= 8'd0;
      subMode_q     <= 8'd0;
      clr_q         <= 1'b1;
      subLast_q     <= 8'd0;
      dwell_q       <= DWELL_W'(1);
      settleCnt_q   <= '0;
      dwellCnt_q    <= '0;
      tryCnt_q      <= '0;
      phase_q       <= 1'b0;
      firstRecv_q   <= '0;
      firstErr_q    <= '0;
      resValid_q    <= 1'b0;
      resMain_q     <= 8'd0;
      resSub_q      <= 8'd0;
      resRecv_q     <= '0;
      resErr_q      <= '0;
      resUnstable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ABORT && (state_q != StIdle)) begin
        state_q    <= StIdle;
        clr_q      <= 1'b1;
        mainMode_q <= 8'd0;
        subMode_q  <= 8'd0;
        resValid_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (START && !ABORT) begin
              state_q     <= StSetup;
              dwell_q     <= dwellEff_d;
              subLast_q   <= SUB_LAST;
              mainMode_q  <= FirstMode;
              subMode_q   <= 8'd0;
              clr_q       <= 1'b1;
              settleCnt_q <= '0;
              busy_q      <= 1'b1;
            end
          end
          StSetup: begin
            if (settleCnt_q == SettleLast) begin
              state_q    <= StRun;
              clr_q      <= 1'b0;
              dwellCnt_q <= DWELL_W'(1);
            end else begin
              settleCnt_q <= settleCnt_q + SETTLE_W'(1);
            end
          end
          StRun: begin
            if (dwellCnt_q == dwell_q) begin
              state_q  <= StSample;
              phase_q  <= 1'b0;
              tryCnt_q <= '0;
            end else begin
              dwellCnt_q <= dwellCnt_q + DWELL_W'(1);
            end
          end
          StSample: begin
            if (!phase_q) begin
              firstRecv_q <= RECV_CNT;
              firstErr_q  <= ERR_CNT;
              phase_q     <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              // Second sample of the pair closes the step, matching or not on the last try.
              if (pairMatch_d || (tryCnt_q == TryLast)) begin
                resRecv_q     <= RECV_CNT;
                resErr_q      <= ERR_CNT;
                resUnstable_q <= !pairMatch_d;
                resMain_q     <= mainMode_q;
                resSub_q      <= subMode_q;
                resValid_q    <= 1'b1;
                state_q       <= StReport;
              end else begin
                tryCnt_q <= tryCnt_q + TRY_W'(1);
              end
            end
          end
          StReport: begin
            if (resValid_q && RES_READY) begin
              resValid_q <= 1'b0;
              if (subMode_q < subLast_q) begin
                subMode_q   <= subMode_q + 8'd1;
                clr_q       <= 1'b1;
                settleCnt_q <= '0;
                state_q     <= StSetup;
              end else if (mainMode_q < LastMode) begin
                mainMode_q  <= mainMode_q + 8'd1;
                subMode_q   <= 8'd0;
                clr_q       <= 1'b1;
                settleCnt_q <= '0;
                state_q     <= StSetup;
              end else begin
                state_q    <= StIdle;
                clr_q      <= 1'b1;
                mainMode_q <= 8'd0;
                subMode_q  <= 8'd0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            clr_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MAIN_MODE    = mainMode_q;
  assign SUB_MODE     = subMode_q;
  assign CLR          = clr_q;
  assign RES_VALID    = resValid_q;
  assign RES_MAIN     = resMain_q;
  assign RES_SUB      = resSub_q;
  assign RES_RECV     = resRecv_q;
  assign RES_ERR      = resErr_q;
  assign RES_UNSTABLE = resUnstable_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule
